// File: rtl/eh2_lsu_ecc_wb_ctl.sv
// DCCM single-ECC writeback controller: queues corrected lo/hi bank data and
// writes it back through the shared DCCM write port, yielding to DMA first.
module eh2_lsu_ecc_wb_ctl #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       ecc_req_valid,
  input  logic                       ecc_req_lo,
  input  logic                       ecc_req_hi,
  input  logic [DCCM_BITS-1:0]       ecc_req_addr_lo,
  input  logic [DCCM_BITS-1:0]       ecc_req_addr_hi,
  input  logic [DCCM_DATA_WIDTH-1:0] ecc_req_data_lo,
  input  logic [DCCM_DATA_WIDTH-1:0] ecc_req_data_hi,
  output logic                       ecc_req_ready,
  input  logic                       dma_wen,
  input  logic                       stbuf_req,
  output logic                       stbuf_grant,
  output logic                       dccm_fix_wen,
  output logic [DCCM_BITS-1:0]       dccm_fix_addr,
  output logic [DCCM_DATA_WIDTH-1:0] dccm_fix_data,
  output logic                       ecc_busy,
  output logic [15:0]                ecc_fix_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  typedef struct packed {
    logic                       lo;
    logic                       hi;
    logic [DCCM_BITS-1:0]       addr_lo;
    logic [DCCM_BITS-1:0]       addr_hi;
    logic [DCCM_DATA_WIDTH-1:0] data_lo;
    logic [DCCM_DATA_WIDTH-1:0] data_hi;
  } entry_t;

  entry_t                     fifo_q [2];
  entry_t                     head;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 occ_q;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  state_t                     state_q;
  state_t                     state_d;
  logic                       fix_go;
  logic [DCCM_BITS-1:0]       fix_addr_c;
  logic [DCCM_DATA_WIDTH-1:0] fix_data_c;

  assign full          = (occ_q == 2'd2);
  assign empty         = (occ_q == 2'd0);
  assign ecc_req_ready = ~full;
  // Requests with neither bank flagged carry nothing to repair, so they are dropped.
  assign push          = ecc_req_valid & ~full & (ecc_req_lo | ecc_req_hi);
  assign head          = fifo_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{lo:      ecc_req_lo,
                          hi:      ecc_req_hi,
                          addr_lo: ecc_req_addr_lo,
                          addr_hi: ecc_req_addr_hi,
                          data_lo: ecc_req_data_lo,
                          data_hi: ecc_req_data_hi};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ_q   <= 2'd0;
      state_q <= IDLE;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ_q   <= occ_q + 2'(push) - 2'(pop);
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fix_go     = 1'b0;
    fix_addr_c = '0;
    fix_data_c = '0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = head.lo ? WR_LO : WR_HI;
      end
      WR_LO: begin
        if (!dma_wen) begin
          fix_go     = 1'b1;
          fix_addr_c = head.addr_lo;
          fix_data_c = head.data_lo;
          if (head.hi) begin
            state_d = WR_HI;
          end else begin
            pop     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR_HI: begin
        if (!dma_wen) begin
          fix_go     = 1'b1;
          fix_addr_c = head.addr_hi;
          fix_data_c = head.data_hi;
          pop        = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are suppressed while reset is held so a pending correction cannot land mid-reset.
  assign dccm_fix_wen  = rst_l & fix_go;
  assign dccm_fix_addr = dccm_fix_wen ? fix_addr_c : '0;
  assign dccm_fix_data = dccm_fix_wen ? fix_data_c : '0;
  assign stbuf_grant   = stbuf_req & ~dma_wen & ~dccm_fix_wen;
  assign ecc_busy      = rst_l & (~empty | (state_q != IDLE));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ecc_fix_count <= 16'd0;
    end else if (dccm_fix_wen && (ecc_fix_count != 16'hFFFF)) begin
      ecc_fix_count <= ecc_fix_count + 16'd1;
    end
  end

endmodule
